// File: rtl/seq_pattern_detect_if.sv
// Serial-stream bus for seq_pattern_detect: bit input, configuration, detect/count status.
// With SEQ_PATTERN_DETECT_MASK_EN defined, a per-position compare mask is added.
interface seq_pattern_detect_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
);
  logic             enable;
  logic             inbits;
  logic [PAT_W-1:0] pattern;
  logic             overlap;
  logic             clear;
`ifdef SEQ_PATTERN_DETECT_MASK_EN
  logic [PAT_W-1:0] mask;
`endif
  logic             detect;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;

  modport master (
    output enable, inbits, pattern, overlap, clear,
`ifdef SEQ_PATTERN_DETECT_MASK_EN
    output mask,
`endif
    input  detect, match_count, count_sat
  );

  modport slave (
    input  enable, inbits, pattern, overlap, clear,
`ifdef SEQ_PATTERN_DETECT_MASK_EN
    input  mask,
`endif
    output detect, match_count, count_sat
  );
endinterface

// File: rtl/seq_pattern_detect.sv
// Parametrised serial bit-sequence detector with overlap control and saturating match count.
// Optional SEQ_PATTERN_DETECT_MASK_EN adds a don't-care mask on the pattern compare.
module seq_pattern_detect #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  seq_pattern_detect_if.slave bus
);
  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam int unsigned HIST_W = PAT_W - 1;

  // Only the newest PAT_W-1 bits are kept; the oldest bit is never needed after the next shift.
  logic [HIST_W-1:0] hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              detect_q, detect_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              sat_q, sat_d;

  logic [PAT_W-1:0]  next_hist;
  logic [FILL_W-1:0] next_fill;
  logic              pat_hit;
  logic              match;

  always_comb begin
    next_hist = {hist_q, bus.inbits};
    next_fill = (fill_q == FILL_W'(PAT_W)) ? fill_q : FILL_W'(fill_q + FILL_W'(1));
`ifdef SEQ_PATTERN_DETECT_MASK_EN
    pat_hit   = ((next_hist ^ bus.pattern) & bus.mask) == '0;
`else
    pat_hit   = next_hist == bus.pattern;
`endif
    match     = bus.enable & ~bus.clear & (next_fill == FILL_W'(PAT_W)) & pat_hit;
  end

  // Next-state: clear wins over an accepted bit; a non-overlapping match restarts the fill.
  always_comb begin
    hist_d   = hist_q;
    fill_d   = fill_q;
    detect_d = 1'b0;
    count_d  = count_q;
    if (bus.clear) begin
      hist_d  = '0;
      fill_d  = '0;
      count_d = '0;
    end else if (bus.enable) begin
      hist_d = next_hist[HIST_W-1:0];
      fill_d = next_fill;
      if (match) begin
        detect_d = 1'b1;
        if (!sat_q) count_d = CNT_W'(count_q + CNT_W'(1));
        if (!bus.overlap) begin
          hist_d = '0;
          fill_d = '0;
        end
      end
    end
    sat_d = &count_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q   <= '0;
      fill_q   <= '0;
      detect_q <= 1'b0;
      count_q  <= '0;
      sat_q    <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      detect_q <= detect_d;
      count_q  <= count_d;
      sat_q    <= sat_d;
    end
  end

  assign bus.detect      = detect_q;
  assign bus.match_count = count_q;
  assign bus.count_sat   = sat_q;
endmodule
